// File: rtl/uart_frame_assembler_pkg.sv
// Shared definitions for the UART frame assembler: FSM encoding, framing constants,
// default reply bytes and error-pulse bit positions.
package uart_frame_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [3:0] SYNC_NIBBLE  = 4'hA;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

  localparam int ERR_W       = 4;
  localparam int ERR_SYNC    = 0;
  localparam int ERR_CSUM    = 1;
  localparam int ERR_INDEX   = 2;
  localparam int ERR_TIMEOUT = 3;

  // XOR of header and the three data bytes, as carried in the trailing CS byte.
  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr, input logic [23:0] data);
    return hdr ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out / reply-out signal bundle of the UART frame assembler.
interface uart_frame_assembler_if;
  import uart_frame_assembler_pkg::*;

  logic [7:0]       rx_data;
  logic             rx_byte_ready;
  logic             frame_valid;
  logic             frame_ready;
  logic [3:0]       frame_index;
  logic [23:0]      frame_data;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [ERR_W-1:0] err;

  modport slave (
    input  rx_data, rx_byte_ready, frame_ready, tx_busy,
    output frame_valid, frame_index, frame_data, tx_data, tx_start, err
  );

  modport master (
    output rx_data, rx_byte_ready, frame_ready, tx_busy,
    input  frame_valid, frame_index, frame_data, tx_data, tx_start, err
  );

endinterface

// File: rtl/uart_frame_assembler_reply.sv
// One-deep ACK/NAK reply holder: launches a single tx_start pulse once the
// transmitter is free; a newer reply replaces one still waiting.
module uart_reply_queue (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       reply_vld_i,
  input  logic [7:0] reply_byte_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);

  logic       pending_q, pending_d;
  logic [7:0] byte_q, byte_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       launch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      byte_q    <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      byte_q    <= byte_d;
      start_q   <= start_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    launch    = pending_q & ~tx_busy_i;
    start_d   = launch;
    data_d    = launch ? byte_q : data_q;
    pending_d = reply_vld_i | (pending_q & ~launch);
    byte_d    = reply_vld_i ? reply_byte_i : byte_q;
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;

endmodule

// File: rtl/uart_frame_assembler.sv
// Turns the UART byte stream into checksummed, index-tagged 24-bit DAC words
// with a valid/ready output and an ACK/NAK reply per completed frame.
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int         DACN           = 1,
  parameter int         TIMEOUT_CYCLES = 16000,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
  input logic                   clock,
  input logic                   reset_n,
  uart_frame_assembler_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [23:0]      data_q, data_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       strobe;
  logic       in_frame;
  logic       tmo_expire;
  logic       cs_ok;
  logic       idx_ok;
  logic       xfer;
  logic       reply_vld;
  logic [7:0] reply_byte;

  assign strobe   = bus.rx_byte_ready;
  assign in_frame = (state_q == ST_DATA) || (state_q == ST_CSUM);
  // Expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES;
  // a strobe arriving on that same cycle takes precedence.
  assign tmo_expire = in_frame && !strobe && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign cs_ok  = frame_checksum({SYNC_NIBBLE, idx_q}, data_q) == bus.rx_data;
  assign idx_ok = int'(idx_q) < DACN;
  assign xfer   = (state_q == ST_HOLD) && bus.frame_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (strobe && bus.rx_data[7:4] == SYNC_NIBBLE) state_d = ST_DATA;
      ST_DATA: begin
        if (strobe && cnt_q == 2'd2) state_d = ST_CSUM;
        else if (tmo_expire)         state_d = ST_IDLE;
      end
      ST_CSUM: begin
        if (strobe)          state_d = (cs_ok && idx_ok) ? ST_HOLD : ST_IDLE;
        else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_HOLD: if (xfer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    err_d      = '0;
    reply_vld  = 1'b0;
    reply_byte = ACK_BYTE;
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          if (bus.rx_data[7:4] == SYNC_NIBBLE) begin
            idx_d = bus.rx_data[3:0];
            cnt_d = '0;
          end else begin
            err_d[ERR_SYNC] = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
          data_d = {data_q[15:0], bus.rx_data};
          cnt_d  = cnt_q + 2'd1;
        end else if (tmo_expire) begin
          err_d[ERR_TIMEOUT] = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CSUM: begin
        if (strobe) begin
          reply_vld = 1'b1;
          if (!cs_ok) begin
            err_d[ERR_CSUM] = 1'b1;
            reply_byte      = NAK_BYTE;
          end else if (!idx_ok) begin
            err_d[ERR_INDEX] = 1'b1;
            reply_byte       = NAK_BYTE;
          end
        end else if (tmo_expire) begin
          err_d[ERR_TIMEOUT] = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  uart_reply_queue u_reply (
    .clock        (clock),
    .reset_n      (reset_n),
    .reply_vld_i  (reply_vld),
    .reply_byte_i (reply_byte),
    .tx_busy_i    (bus.tx_busy),
    .tx_start_o   (bus.tx_start),
    .tx_data_o    (bus.tx_data)
  );

  assign bus.frame_valid = (state_q == ST_HOLD);
  assign bus.frame_index = idx_q;
  assign bus.frame_data  = data_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: directed cases plus a random byte stream
// judged by a queue-based frame model.
module tb_uart_frame_assembler;
  import uart_frame_assembler_pkg::*;

  localparam int DACN = 1;
  localparam int TMO  = 40;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  uart_frame_assembler_if bus ();

  uart_frame_assembler #(
    .DACN           (DACN),
    .TIMEOUT_CYCLES (TMO),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int nstart = 0;

  logic [27:0] exp_frame[$];
  logic [7:0]  exp_tx[$];
  logic [3:0]  exp_err[$];
  logic [7:0]  mbuf[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: collect bytes into a frame buffer and judge each complete frame.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    if (mbuf.size() == 0) begin
      if (b[7:4] != 4'hA) exp_err.push_back(4'b0001);
      else mbuf.push_back(b);
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == 5) begin
        x = mbuf[0] ^ mbuf[1] ^ mbuf[2] ^ mbuf[3];
        if (x != mbuf[4]) begin
          exp_err.push_back(4'b0010);
          exp_tx.push_back(8'h15);
        end else if (int'(mbuf[0] & 8'h0F) >= DACN) begin
          exp_err.push_back(4'b0100);
          exp_tx.push_back(8'h15);
        end else begin
          exp_tx.push_back(8'h06);
          exp_frame.push_back({mbuf[0][3:0], mbuf[1], mbuf[2], mbuf[3]});
        end
        mbuf.delete();
      end
    end
  endtask

  task automatic model_idle(input int idle);
    if (mbuf.size() != 0 && idle >= TMO) begin
      exp_err.push_back(4'b1000);
      mbuf.delete();
    end
  endtask

  task automatic drive(input logic [7:0] b, input int idle);
    bus.rx_data       = b;
    bus.rx_byte_ready = 1'b1;
    @(posedge clock); #1;
    bus.rx_byte_ready = 1'b0;
    repeat (idle) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    model_byte(b);
    model_idle(idle);
    drive(b, idle);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [23:0] d, input logic [7:0] cs, input int last_idle);
    send(hdr, 2);
    send(d[23:16], 2);
    send(d[15:8], 2);
    send(d[7:0], 2);
    send(cs, last_idle);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
    check({tag, "_index"}, 32'(bus.frame_index), 32'd0);
    check({tag, "_data"},  32'(bus.frame_data),  32'd0);
    check({tag, "_start"}, 32'(bus.tx_start),    32'd0);
    check({tag, "_txdata"},32'(bus.tx_data),     32'd0);
    check({tag, "_err"},   32'(bus.err),         32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  logic [27:0] hold_prev;
  logic        hold_seen = 1'b0;
  logic [3:0]  e_pop;
  logic [27:0] f_pop;
  logic [7:0]  t_pop;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.err != 4'b0) begin
        check("err_onehot", 32'($onehot(bus.err)), 32'd1);
        if (exp_err.size() == 0) check("err_unexpected", 32'(bus.err), 32'd0);
        else begin
          e_pop = exp_err.pop_front();
          check("err_pulse", 32'(bus.err), 32'(e_pop));
        end
      end
      if (bus.tx_start) begin
        nstart++;
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
        else begin
          t_pop = exp_tx.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(t_pop));
        end
      end
      if (bus.frame_valid && hold_seen)
        check("hold_stable", 32'({bus.frame_index, bus.frame_data}), 32'(hold_prev));
      if (bus.frame_valid && bus.frame_ready) begin
        if (exp_frame.size() == 0) check("frame_unexpected", 32'({bus.frame_index, bus.frame_data}), 32'hFFFF_FFFF);
        else begin
          f_pop = exp_frame.pop_front();
          check("frame_word", 32'({bus.frame_index, bus.frame_data}), 32'(f_pop));
        end
      end
      hold_seen = bus.frame_valid && !bus.frame_ready;
      hold_prev = {bus.frame_index, bus.frame_data};
    end else begin
      hold_seen = 1'b0;
    end
  end

  initial begin
    logic [7:0]  hdr, cs;
    logic [23:0] d;
    int          n0, idle, r;

    reset_n           = 1'b0;
    bus.rx_data       = 8'h00;
    bus.rx_byte_ready = 1'b0;
    bus.frame_ready   = 1'b1;
    bus.tx_busy       = 1'b0;
    wait_cycles(3);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    wait_cycles(2);

    // Basic accept, checksum error, index error.
    send_frame(8'hA0, 24'h123456, 8'hD0, 2);
    send_frame(8'hA0, 24'h123456, 8'hD1, 2);
    send_frame(8'hA1, 24'h123456, 8'hD1, 2);

    // Sync error followed by a good frame.
    send(8'h55, 2);
    send_frame(8'hA0, 24'hABCDEF, 8'hA0 ^ 8'hAB ^ 8'hCD ^ 8'hEF, 2);

    // Gap one short of the limit survives; a full-limit gap times out.
    send(8'hA0, 1);
    send(8'h12, TMO - 1);
    send(8'h34, 1);
    send(8'h56, 1);
    send(8'hD0, 2);
    send(8'hA0, 1);
    send(8'h12, TMO);
    send_frame(8'hA0, 24'h0F00F0, 8'hA0 ^ 8'h0F ^ 8'h00 ^ 8'hF0, 4);

    // Backpressure: frame held while extra bytes are ignored.
    bus.frame_ready = 1'b0;
    send_frame(8'hA0, 24'h5A5AA5, 8'hA0 ^ 8'h5A ^ 8'h5A ^ 8'hA5, 1);
    drive(8'hA0, 2);
    drive(8'h33, 2);
    drive(8'h77, 2);
    wait_cycles(100);
    check("hold_valid", 32'(bus.frame_valid), 32'd1);
    check("hold_data", 32'(bus.frame_data), 32'h5A5AA5);
    bus.frame_ready = 1'b1;
    wait_cycles(3);
    check("hold_released", 32'(bus.frame_valid), 32'd0);

    // Reset mid-frame.
    wait_cycles(10);
    send(8'hA0, 1);
    send(8'h12, 1);
    send(8'h34, 1);
    reset_n = 1'b0;
    #2;
    mbuf.delete();
    check_zero_outputs("midreset");
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);
    send_frame(8'hA0, 24'h00C0DE, 8'hA0 ^ 8'h00 ^ 8'hC0 ^ 8'hDE, 4);

    // Transmitter busy delays the ACK.
    wait_cycles(10);
    bus.tx_busy = 1'b1;
    n0 = nstart;
    send_frame(8'hA0, 24'h987654, 8'hA0 ^ 8'h98 ^ 8'h76 ^ 8'h54, 2);
    wait_cycles(20);
    check("busy_holdoff", 32'(nstart), 32'(n0));
    bus.tx_busy = 1'b0;
    wait_cycles(5);
    check("busy_release", 32'(nstart), 32'(n0 + 1));

    // Random byte stream judged by the model.
    for (int k = 0; k < 250; k++) begin
      r   = int'($urandom_range(0, 9));
      hdr = (r == 0) ? 8'($urandom) : {4'hA, (r == 1) ? 4'($urandom) : 4'h0};
      d   = 24'($urandom);
      cs  = hdr ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if ($urandom_range(0, 5) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      for (int j = 0; j < 5; j++) begin
        r = int'($urandom_range(0, 29));
        if (r == 0)      idle = TMO + int'($urandom_range(0, 3));
        else if (r == 1) idle = TMO - 1;
        else             idle = int'($urandom_range(1, 4));
        case (j)
          0: send(hdr, idle);
          1: send(d[23:16], idle);
          2: send(d[15:8], idle);
          3: send(d[7:0], idle);
          default: send(cs, idle);
        endcase
      end
    end

    // Drain: any partial frame will time out.
    model_idle(TMO);
    wait_cycles(TMO + 20);
    check("left_frames", 32'(exp_frame.size()), 32'd0);
    check("left_replies", 32'(exp_tx.size()), 32'd0);
    check("left_errors", 32'(exp_err.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
